// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared types and constants for the LDM/STM block-transfer sequencer.
// Imported by the sequencer top and its helpers.
package ldm_stm_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StXfer  = 2'd1,
        StWback = 2'd2,
        StDone  = 2'd3
    } state_e;

    // Addressing mode keyed by {P, U}.
    typedef enum logic [1:0] {
        ModeDa = 2'b00,
        ModeIa = 2'b01,
        ModeDb = 2'b10,
        ModeIb = 2'b11
    } mode_e;

endpackage

// File: rtl/ldm_stm_sequencer_if.sv
// Control/memory/register-file bundle for ldm_stm_sequencer.
// LDM_STM_PC_FLUSH_EN adds the pc_flush_out signal.
interface ldm_stm_sequencer_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              start_in;
    logic              is_load_in;
    logic              p_bit_in;
    logic              u_bit_in;
    logic              w_bit_in;
    logic [15:0]       reg_list_in;
    logic [ADDR_W-1:0] base_in;
    logic              mem_ready_in;

    logic              mem_req_out;
    logic              mem_we_out;
    logic [ADDR_W-1:0] mem_addr_out;
    logic [3:0]        reg_addr_out;
    logic              rf_we_out;
    logic              base_wb_en_out;
    logic [ADDR_W-1:0] base_wb_data_out;
    logic              busy_out;
    logic              done_out;
`ifdef LDM_STM_PC_FLUSH_EN
    logic              pc_flush_out;
`endif

    modport slave (
`ifdef LDM_STM_PC_FLUSH_EN
        output pc_flush_out,
`endif
        input  start_in, is_load_in, p_bit_in, u_bit_in, w_bit_in, reg_list_in, base_in,
        input  mem_ready_in,
        output mem_req_out, mem_we_out, mem_addr_out, reg_addr_out, rf_we_out,
        output base_wb_en_out, base_wb_data_out, busy_out, done_out
    );

    modport master (
`ifdef LDM_STM_PC_FLUSH_EN
        input  pc_flush_out,
`endif
        output start_in, is_load_in, p_bit_in, u_bit_in, w_bit_in, reg_list_in, base_in,
        output mem_ready_in,
        input  mem_req_out, mem_we_out, mem_addr_out, reg_addr_out, rf_we_out,
        input  base_wb_en_out, base_wb_data_out, busy_out, done_out
    );

endinterface

// File: rtl/ldm_stm_sequencer_lowest_bit.sv
// Find-first-set over the pending register mask: index of the lowest set bit
// and the mask with that bit removed.
module ldm_stm_lowest_bit (
    input  logic [15:0] mask,
    output logic [3:0]  idx,
    output logic [15:0] mask_clr
);

    always_comb begin
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) begin
                idx = 4'(i);
            end
        end
    end

    assign mask_clr = mask & (mask - 16'd1);

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: walks the register list lowest-first, one word per
// memory handshake, then optional base writeback. LDM_STM_PC_FLUSH_EN adds pc_flush_out.
module ldm_stm_sequencer #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned WORD_BYTES = ldm_stm_pkg::WORD_BYTES
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    ldm_stm_sequencer_if.slave    bus
);
    import ldm_stm_pkg::*;

    localparam logic [ADDR_W-1:0] Step = ADDR_W'(WORD_BYTES);

    state_e            state_q;
    logic [15:0]       mask_q;
    logic [4:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] wb_q;
    logic              load_q;
    logic              w_q;

    logic [4:0]        cnt_d;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] wb_d;
    mode_e             mode;

    logic [3:0]        low_idx;
    logic [15:0]       mask_clr;

    ldm_stm_lowest_bit u_lowest_bit (
        .mask     (mask_q),
        .idx      (low_idx),
        .mask_clr (mask_clr)
    );

    // Capture-time address arithmetic, all modulo 2^ADDR_W.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < 16; i++) begin
            cnt_d = cnt_d + 5'(bus.reg_list_in[i]);
        end
        offset     = ADDR_W'(cnt_d) * Step;
        mode       = mode_e'({bus.p_bit_in, bus.u_bit_in});
        start_addr = bus.base_in;
        case (mode)
            ModeIa:  start_addr = bus.base_in;
            ModeIb:  start_addr = bus.base_in + Step;
            ModeDa:  start_addr = bus.base_in - offset + Step;
            ModeDb:  start_addr = bus.base_in - offset;
            default: start_addr = bus.base_in;
        endcase
        wb_d = bus.u_bit_in ? bus.base_in + offset : bus.base_in - offset;
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= StIdle;
            mask_q  <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wb_q    <= '0;
            load_q  <= 1'b0;
            w_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start_in) begin
                        mask_q  <= bus.reg_list_in;
                        cnt_q   <= cnt_d;
                        addr_q  <= start_addr;
                        wb_q    <= wb_d;
                        load_q  <= bus.is_load_in;
                        w_q     <= bus.w_bit_in;
                        state_q <= (bus.reg_list_in == 16'd0) ? StDone : StXfer;
                    end
                end
                StXfer: begin
                    if (bus.mem_ready_in) begin
                        mask_q <= mask_clr;
                        cnt_q  <= cnt_q - 5'd1;
                        addr_q <= addr_q + Step;
                        if (cnt_q == 5'd1) begin
                            state_q <= w_q ? StWback : StDone;
                        end
                    end
                end
                StWback: state_q <= StDone;
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    logic xfer;
    assign xfer = (state_q == StXfer);

    // Everything decodes from registered state, so reset clears outputs asynchronously.
    assign bus.mem_req_out      = xfer;
    assign bus.mem_we_out       = xfer & ~load_q;
    assign bus.mem_addr_out     = xfer ? addr_q : '0;
    assign bus.reg_addr_out     = xfer ? low_idx : '0;
    assign bus.rf_we_out        = xfer & load_q & bus.mem_ready_in;
    assign bus.base_wb_en_out   = (state_q == StWback);
    assign bus.base_wb_data_out = (state_q == StWback) ? wb_q : '0;
    assign bus.busy_out         = (state_q != StIdle);
    assign bus.done_out         = (state_q == StDone);

`ifdef LDM_STM_PC_FLUSH_EN
    logic r15_load_q;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r15_load_q <= 1'b0;
        end else if ((state_q == StIdle) && bus.start_in) begin
            r15_load_q <= bus.is_load_in & bus.reg_list_in[15];
        end
    end

    assign bus.pc_flush_out = (state_q == StDone) & r15_load_q;
`else
    // R15 loads only update the register file; no fetch flush is signalled.
`endif

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: expected transfers are queued at start and
// popped as the DUT completes each memory handshake.
module tb_ldm_stm_sequencer;

    typedef struct {
        logic [3:0]  r;
        logic [31:0] a;
    } xfer_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   asserts = 0;
    int   fails = 0;

    xfer_t       xfer_q[$];
    logic [31:0] wb_q[$];

    ldm_stm_sequencer_if #(.ADDR_W(32)) bus ();

    ldm_stm_sequencer #(
        .ADDR_W     (32),
        .WORD_BYTES (4)
    ) dut (
        .clk_in   (clk),
        .reset_in (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check_all_zero(input string name);
        logic [31:0] f;
        f = 32'(bus.mem_req_out) | 32'(bus.mem_we_out) | bus.mem_addr_out |
            32'(bus.reg_addr_out) | 32'(bus.rf_we_out) | 32'(bus.base_wb_en_out) |
            bus.base_wb_data_out | 32'(bus.busy_out) | 32'(bus.done_out);
`ifdef LDM_STM_PC_FLUSH_EN
        f = f | 32'(bus.pc_flush_out);
`endif
        asserts++;
        if (f !== 32'd0) begin
            fails++;
            $display("FAIL %s: outputs OR-ed got %h expected 0", name, f);
        end
    endtask

    task automatic push_x(input logic [3:0] r, input logic [31:0] a);
        xfer_t t;
        t.r = r;
        t.a = a;
        xfer_q.push_back(t);
    endtask

    // Drives one start and follows the sequence to done_out, scoring each cycle.
    task automatic run_sequence(input string name, input logic ld, input logic p,
                                input logic u, input logic w, input logic [15:0] list,
                                input logic [31:0] base, input int stall, input bit poke,
                                input int exp_done, input logic exp_flush);
        bit    seen_done = 0;
        xfer_t e;
        @(negedge clk);
        bus.is_load_in  = ld;
        bus.p_bit_in    = p;
        bus.u_bit_in    = u;
        bus.w_bit_in    = w;
        bus.reg_list_in = list;
        bus.base_in     = base;
        bus.start_in    = 1'b1;
        for (int cyc = 1; cyc <= 40 && !seen_done; cyc++) begin
            @(negedge clk);
            bus.start_in     = poke && (cyc == 2);
            if (poke && cyc == 2) begin
                bus.reg_list_in = 16'hFFFF;
                bus.is_load_in  = ~ld;
                bus.base_in     = 32'hDEAD_0000;
            end
            bus.mem_ready_in = (cyc > stall);
            #1;
            asserts++;
            if (bus.busy_out !== 1'b1) begin
                fails++;
                $display("FAIL %s busy c%0d: got %b expected 1", name, cyc, bus.busy_out);
            end
            if (bus.mem_req_out === 1'b1) begin
                asserts++;
                if (xfer_q.size() == 0) begin
                    fails++;
                    $display("FAIL %s extra_req c%0d: got req expected none", name, cyc);
                end else begin
                    e = xfer_q[0];
                    if (bus.reg_addr_out !== e.r || bus.mem_addr_out !== e.a ||
                        bus.mem_we_out !== ~ld ||
                        bus.rf_we_out !== (ld & bus.mem_ready_in)) begin
                        fails++;
                        $display("FAIL %s xfer c%0d: got r%0d @%h we%b rfwe%b expected r%0d @%h we%b rfwe%b",
                                 name, cyc, bus.reg_addr_out, bus.mem_addr_out, bus.mem_we_out,
                                 bus.rf_we_out, e.r, e.a, ~ld, ld & bus.mem_ready_in);
                    end
                    if (bus.mem_ready_in) void'(xfer_q.pop_front());
                end
            end
            if (bus.base_wb_en_out === 1'b1) begin
                asserts++;
                if (wb_q.size() == 0) begin
                    fails++;
                    $display("FAIL %s extra_wb c%0d: got %h expected none", name, cyc,
                             bus.base_wb_data_out);
                end else begin
                    if (bus.base_wb_data_out !== wb_q[0]) begin
                        fails++;
                        $display("FAIL %s wb_data: got %h expected %h", name,
                                 bus.base_wb_data_out, wb_q[0]);
                    end
                    void'(wb_q.pop_front());
                end
            end
            if (bus.done_out === 1'b1) begin
                seen_done = 1;
                asserts++;
                if (cyc != exp_done || xfer_q.size() != 0 || wb_q.size() != 0) begin
                    fails++;
                    $display("FAIL %s done: got cycle %0d (left x%0d wb%0d) expected cycle %0d (left 0 0)",
                             name, cyc, xfer_q.size(), wb_q.size(), exp_done);
                end
`ifdef LDM_STM_PC_FLUSH_EN
                asserts++;
                if (bus.pc_flush_out !== exp_flush) begin
                    fails++;
                    $display("FAIL %s pc_flush: got %b expected %b", name, bus.pc_flush_out,
                             exp_flush);
                end
`else
                if (exp_flush) begin end
`endif
            end
        end
        if (!seen_done) begin
            asserts++;
            fails++;
            $display("FAIL %s timeout: got no done expected done at cycle %0d", name, exp_done);
        end
        @(negedge clk);
        #1;
        check_all_zero({name, " idle_after"});
        xfer_q.delete();
        wb_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_all_zero("reset_release");
    endtask

    task automatic test_ldm_ia();
        push_x(4'd0, 32'h1000);
        push_x(4'd1, 32'h1004);
        push_x(4'd3, 32'h1008);
        wb_q.push_back(32'h100C);
        run_sequence("ldm_ia", 1'b1, 1'b0, 1'b1, 1'b1, 16'h000B, 32'h1000, 0, 0, 5, 1'b0);
    endtask

    task automatic test_stm_db_busy_start();
        push_x(4'd4, 32'h1FF8);
        push_x(4'd14, 32'h1FFC);
        wb_q.push_back(32'h1FF8);
        run_sequence("stm_db", 1'b0, 1'b1, 1'b0, 1'b1, 16'h4010, 32'h2000, 0, 1, 4, 1'b0);
    endtask

    task automatic test_stall();
        push_x(4'd0, 32'h3004);
        push_x(4'd1, 32'h3008);
        run_sequence("stall_ib", 1'b0, 1'b1, 1'b1, 1'b0, 16'h0003, 32'h3000, 3, 0, 6, 1'b0);
    endtask

    task automatic test_empty();
        run_sequence("empty", 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 32'h7000, 0, 0, 1, 1'b0);
    endtask

    task automatic test_da_flush();
        push_x(4'd0, 32'h00FC);
        push_x(4'd15, 32'h0100);
        wb_q.push_back(32'h00F8);
        run_sequence("ldm_da", 1'b1, 1'b0, 1'b0, 1'b1, 16'h8001, 32'h0100, 0, 0, 4, 1'b1);
        push_x(4'd0, 32'h00FC);
        push_x(4'd15, 32'h0100);
        run_sequence("stm_da", 1'b0, 1'b0, 1'b0, 1'b0, 16'h8001, 32'h0100, 0, 0, 3, 1'b0);
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        bus.is_load_in   = 1'b1;
        bus.p_bit_in     = 1'b0;
        bus.u_bit_in     = 1'b1;
        bus.w_bit_in     = 1'b1;
        bus.reg_list_in  = 16'h000F;
        bus.base_in      = 32'h4000;
        bus.mem_ready_in = 1'b1;
        bus.start_in     = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b0;
        @(negedge clk);
        #1;
        asserts++;
        if (bus.mem_req_out !== 1'b1 || bus.reg_addr_out !== 4'd1 ||
            bus.mem_addr_out !== 32'h4004) begin
            fails++;
            $display("FAIL abort_pre: got req%b r%0d @%h expected req1 r1 @00004004",
                     bus.mem_req_out, bus.reg_addr_out, bus.mem_addr_out);
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("abort_async");
        @(negedge clk);
        check_all_zero("abort_held");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check_all_zero("abort_no_wb");
        end
    endtask

    task automatic test_back_to_back();
        push_x(4'd0, 32'h5000);
        push_x(4'd2, 32'h5004);
        wb_q.push_back(32'h5008);
        run_sequence("restart_a", 1'b0, 1'b0, 1'b1, 1'b1, 16'h0005, 32'h5000, 0, 0, 4, 1'b0);
        push_x(4'd7, 32'hFFFF_FFFC);
        wb_q.push_back(32'h0000_0000);
        run_sequence("wrap_ia", 1'b1, 1'b0, 1'b1, 1'b1, 16'h0080, 32'hFFFF_FFFC, 0, 0, 3, 1'b0);
    endtask

    initial begin
        bus.start_in     = 1'b0;
        bus.is_load_in   = 1'b0;
        bus.p_bit_in     = 1'b0;
        bus.u_bit_in     = 1'b0;
        bus.w_bit_in     = 1'b0;
        bus.reg_list_in  = 16'h0000;
        bus.base_in      = 32'h0;
        bus.mem_ready_in = 1'b1;
        test_reset();
        test_ldm_ia();
        test_stm_db_busy_start();
        test_stall();
        test_empty();
        test_da_flush();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/ldm_stm_sequencer.md
Name: ldm_stm_sequencer

Overview:
- Multi-cycle controller for ARM LDM/STM block transfers.
- On a start pulse, walks the 16-bit register list lowest-numbered register first, one transfer per memory handshake.
- Generates the word address, the register-file address and the load write-enable for each transfer, then performs optional base writeback.
- Sits between decode/execute control and the register file / data memory port; the pipeline is stalled while busy_out is high.

Parameters:
- ADDR_W, 32, width of base and memory address.
- WORD_BYTES, 4, address increment per transferred register.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- reset_in  input  1  asynchronous, active-low reset.
- start_in  input  1  one-cycle pulse; sampled only in IDLE.
- is_load_in  input  1  1 = LDM, 0 = STM.
- p_bit_in  input  1  pre-index (before) when 1.
- u_bit_in  input  1  increment when 1, decrement when 0.
- w_bit_in  input  1  base writeback enable.
- reg_list_in  input  16  register list; bit n selects Rn.
- base_in  input  ADDR_W  base register value.
- mem_ready_in  input  1  memory accepted/completed the current word.
- mem_req_out  output  1  memory request valid.
- mem_we_out  output  1  1 = write (STM).
- mem_addr_out  output  ADDR_W  word address of the current transfer.
- reg_addr_out  output  4  register currently transferred.
- rf_we_out  output  1  load writeback strobe for reg_addr_out.
- base_wb_en_out  output  1  one-cycle base writeback strobe.
- base_wb_data_out  output  ADDR_W  new base value.
- busy_out  output  1  sequence in progress.
- done_out  output  1  one-cycle completion pulse.

Behaviour:
- Reset: state IDLE. All outputs 0; internal mask, count and address registers cleared.
- Capture in IDLE on start_in:
  - Latch reg_list_in into a pending mask, and latch is_load/p/u/w and base.
  - n = popcount(reg_list_in), 0..16, held in a 5-bit register.
  - Start address by mode:
    - IA (P=0, U=1): base
    - IB (P=1, U=1): base + 4
    - DA (P=0, U=0): base - 4n + 4
    - DB (P=1, U=0): base - 4n
  - Writeback value: base + 4n if U=1, else base - 4n. All arithmetic is modulo 2^ADDR_W.
- States:
  - IDLE -> XFER on start_in with a non-empty list.
  - IDLE -> DONE on start_in with an empty list: no transfers, no writeback.
  - XFER: mem_req_out = 1; mem_we_out = ~is_load. reg_addr_out = lowest set bit of the pending mask; mem_addr_out = current address. Outputs stay stable until mem_ready_in.
  - On mem_ready_in in XFER:
    - rf_we_out pulses for one cycle if is_load (same cycle as mem_ready_in).
    - Clear that bit from the mask; address += 4.
    - Mask now empty -> WBACK if W, else DONE. Otherwise stay in XFER.
    - Back-to-back transfers are allowed: one per cycle when mem_ready_in is held high.
  - WBACK: base_wb_en_out = 1 for one cycle -> DONE.
    - Writeback is suppressed for LDM with the base register in the list (the loaded value wins). Base register number comes from the separate decode field and is outside this block, so suppression is signalled by the decode stage clearing w_bit_in.
  - DONE: done_out = 1 for one cycle -> IDLE.
- busy_out = 1 in XFER, WBACK and DONE.
- start_in while busy is ignored.
- Reset asserted mid-sequence aborts immediately: mem_req_out drops asynchronously and no writeback occurs.
- Latency: n + 1 (+1 if writeback) cycles from start to done_out with memory always ready.

Optional Feature:
- Macro: LDM_STM_PC_FLUSH_EN.
- Defined: adds output pc_flush_out (1 bit). It pulses together with done_out when an LDM transferred R15 (bit 15 of the list), to flush the fetch pipeline.
- Undefined: port absent; an R15 load only writes the register file.

Decomposition:
- Package ldm_stm_pkg holds:
  - state encoding constants: IDLE=2'd0, XFER=2'd1, WBACK=2'd2, DONE=2'd3;
  - WORD_BYTES;
  - the addressing-mode encoding {P,U}.
- Sub-module ldm_stm_lowest_bit: combinational find-first-set over the pending mask. Outputs: the 4-bit index and the mask with that bit cleared.
- Popcount stays inline.

Test Plan:
- LDM IA, list 16'h000B, base 0x1000, W=1, ready always 1:
  - reg_addr 0,1,3 at addr 0x1000, 0x1004, 0x1008;
  - rf_we each cycle;
  - base_wb_data 0x100C;
  - done 5 cycles after start.
- STM DB, list 16'h4010, base 0x2000, W=1: mem_we=1 with reg 4 @0x1FF8, then reg 14 @0x1FFC; base_wb 0x1FF8.
- Stall: STM IB, list 16'h0003, base 0x3000, mem_ready low 3 cycles on the first word: addr 0x3004 and reg 0 held stable; then reg 1 @0x3008; no writeback with W=0.
- Empty list with start: no mem_req; done_out one cycle later; base_wb_en stays 0.
- Reset low during the second transfer of a 4-register LDM: all outputs 0 immediately. A new start after release runs cleanly from IDLE.
- With LDM_STM_PC_FLUSH_EN defined, LDM DA list 16'h8001, base 0x100: addrs 0xFC, 0x100; pc_flush_out pulses with done. For the same list as STM, no pulse.
